// File: rtl/ibex_mul_arb_pkg.sv
// ============================================================================
// ibex_mul_arb_pkg : shared types and constants for the multiplier arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package ibex_mul_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_MDV  = 2'd1,
    OWN_NU   = 2'd2
  } owner_e;

  localparam int unsigned MUL_LANES  = 4;
  localparam int unsigned MUL_LANE_W = 17;
  localparam int unsigned MUL_PROD_W = 34;
  localparam int unsigned NU_PROD_W  = 32;

endpackage

`default_nettype wire

// File: rtl/ibex_mul_arb_prio.sv
// ============================================================================
// ibex_mul_arb_prio : grant priority with NU burst lock and starvation counter
// Revision 1.0
// ============================================================================
`default_nettype none

module ibex_mul_arb_prio
  import ibex_mul_arb_pkg::*;
#(
  parameter int unsigned MaxWait = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic mdv_req_i,
  input  logic nu_req_i,
  input  logic nu_lock_i,
  output logic mdv_gnt_o,
  output logic nu_gnt_o
);

  localparam logic [3:0] MaxWaitC = 4'(MaxWait);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       lock_q, lock_d;

  // Grants are suppressed while reset is held so nothing is issued mid-reset.
  always_comb begin
    mdv_gnt_o = 1'b0;
    nu_gnt_o  = 1'b0;
    if (!rst_ni) begin
      mdv_gnt_o = 1'b0;
    end else if (lock_q && nu_req_i) begin
      nu_gnt_o = 1'b1;
    end else if ((wait_cnt_q == MaxWaitC) && nu_req_i) begin
      nu_gnt_o = 1'b1;
    end else if (mdv_req_i) begin
      mdv_gnt_o = 1'b1;
    end else if (nu_req_i) begin
      nu_gnt_o = 1'b1;
    end
  end

  always_comb begin
    lock_d     = nu_gnt_o & nu_lock_i;
    wait_cnt_d = wait_cnt_q;
    if (!nu_req_i || nu_gnt_o) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != MaxWaitC) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q <= 4'd0;
      lock_q     <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      lock_q     <= lock_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ibex_mul_arbiter.sv
// ============================================================================
// ibex_mul_arbiter : shares the 4-lane multiplier between MDV and NU, 1-cycle
// latency. Optional perf counters under IBEX_MUL_ARB_PERF_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module ibex_mul_arbiter
  import ibex_mul_arb_pkg::*;
#(
  parameter int unsigned MaxWait = 4,
  parameter int unsigned LaneW   = MUL_LANE_W,
  parameter int unsigned Lanes   = MUL_LANES
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          mdv_req_i,
  input  logic [Lanes*LaneW-1:0]        mdv_w_i,
  input  logic [Lanes*LaneW-1:0]        mdv_a_i,
  input  logic                          mdv_normal_i,
  output logic                          mdv_gnt_o,
  output logic                          mdv_rsp_valid_o,
  output logic [Lanes*MUL_PROD_W-1:0]   mdv_prod_o,
  input  logic                          nu_req_i,
  input  logic                          nu_lock_i,
  input  logic [Lanes*LaneW-1:0]        nu_w_i,
  input  logic [Lanes*LaneW-1:0]        nu_a_i,
  output logic                          nu_gnt_o,
  output logic                          nu_rsp_valid_o,
  output logic [Lanes*NU_PROD_W-1:0]    nu_prod_o,
  output logic [Lanes*LaneW-1:0]        mul_w_o,
  output logic [Lanes*LaneW-1:0]        mul_a_o,
  output logic                          mul_normal_o,
  input  logic [Lanes*MUL_PROD_W-1:0]   mul_prod_i,
`ifdef IBEX_MUL_ARB_PERF_EN
  output logic [95:0]                   perf_cnt_o,
`endif
  output logic                          busy_o
);

  localparam int unsigned OpW = Lanes * LaneW;

  owner_e         owner_q, owner_d;
  logic [OpW-1:0] w_q, w_d, a_q, a_d;
  logic           normal_q, normal_d;

  ibex_mul_arb_prio #(.MaxWait(MaxWait)) u_prio (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .mdv_req_i (mdv_req_i),
    .nu_req_i  (nu_req_i),
    .nu_lock_i (nu_lock_i),
    .mdv_gnt_o (mdv_gnt_o),
    .nu_gnt_o  (nu_gnt_o)
  );

  // Operands hold on idle cycles so the array inputs do not toggle.
  always_comb begin
    owner_d  = OWN_NONE;
    w_d      = w_q;
    a_d      = a_q;
    normal_d = normal_q;
    if (mdv_gnt_o) begin
      owner_d  = OWN_MDV;
      w_d      = mdv_w_i;
      a_d      = mdv_a_i;
      normal_d = mdv_normal_i;
    end else if (nu_gnt_o) begin
      owner_d  = OWN_NU;
      w_d      = nu_w_i;
      a_d      = nu_a_i;
      normal_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q  <= OWN_NONE;
      w_q      <= '0;
      a_q      <= '0;
      normal_q <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      w_q      <= w_d;
      a_q      <= a_d;
      normal_q <= normal_d;
    end
  end

  assign mul_w_o         = w_q;
  assign mul_a_o         = a_q;
  assign mul_normal_o    = normal_q;
  assign mdv_rsp_valid_o = (owner_q == OWN_MDV);
  assign nu_rsp_valid_o  = (owner_q == OWN_NU);
  assign busy_o          = (owner_q != OWN_NONE);
  assign mdv_prod_o      = mdv_rsp_valid_o ? mul_prod_i : '0;

  for (genvar k = 0; k < Lanes; k++) begin : g_nu_lane
    assign nu_prod_o[k*NU_PROD_W +: NU_PROD_W] =
        nu_rsp_valid_o ? mul_prod_i[k*MUL_PROD_W +: NU_PROD_W] : '0;
  end

`ifdef IBEX_MUL_ARB_PERF_EN
  logic [31:0] mdv_cnt_q, nu_cnt_q, conf_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mdv_cnt_q  <= '0;
      nu_cnt_q   <= '0;
      conf_cnt_q <= '0;
    end else begin
      if (mdv_gnt_o)              mdv_cnt_q  <= mdv_cnt_q + 32'd1;
      if (nu_gnt_o)               nu_cnt_q   <= nu_cnt_q + 32'd1;
      if (mdv_req_i && nu_req_i)  conf_cnt_q <= conf_cnt_q + 32'd1;
    end
  end

  assign perf_cnt_o = {conf_cnt_q, nu_cnt_q, mdv_cnt_q};
`endif

endmodule

`default_nettype wire
